// File: rtl/decode_stage.sv
// Instruction decode stage: field extraction, control decode, 32x32 register file
// with write-through bypass, load-use stall detection and the ID/EX pipeline register.
module decode_stage (
   input  logic         clk,
   input  logic         rst,
   input  logic [63:0]  IF_ID,
   input  logic         wb_we,
   input  logic [4:0]   wb_rd,
   input  logic [31:0]  wb_data,
   input  logic         flush,
   output logic         stall,
   output logic [151:0] ID_EX
);

   logic [31:0] pc4, instr;
   logic [5:0]  opcode;
   logic [4:0]  rs, rt, rd;
   logic [31:0] imm;
   logic [8:0]  ctrl;
   logic [31:0] rs_data, rt_data;
   logic [31:0] regs [32];
   logic        wr_ok;
   logic [4:0]  ex_rt;

   assign pc4    = IF_ID[63:32];
   assign instr  = IF_ID[31:0];
   assign opcode = instr[31:26];
   assign rs     = instr[25:21];
   assign rt     = instr[20:16];
   assign rd     = instr[15:11];
   assign imm    = {{16{instr[15]}}, instr[15:0]};

   // ctrl = {RegWrite, MemtoReg, Branch, MemRead, MemWrite, RegDst, ALUSrc, ALUOp[1:0]}
   always_comb begin
      ctrl = '0;
      case (opcode)
         6'd0:    ctrl = 9'b1_0_0_0_0_1_0_10;
         6'd35:   ctrl = 9'b1_1_0_1_0_0_1_00;
         6'd43:   ctrl = 9'b0_0_0_0_1_0_1_00;
         6'd4:    ctrl = 9'b0_0_1_0_0_0_0_01;
         6'd8:    ctrl = 9'b1_0_0_0_0_0_1_00;
         default: ctrl = '0;
      endcase
   end

   assign wr_ok = wb_we && (wb_rd != 5'd0) && !rst;

   // r0 is hardwired; a same-cycle writeback wins over the stored value
   always_comb begin
      rs_data = regs[rs];
      rt_data = regs[rt];
      if (wr_ok && wb_rd == rs) rs_data = wb_data;
      if (wr_ok && wb_rd == rt) rt_data = wb_data;
      if (rs == 5'd0 || rst)    rs_data = '0;
      if (rt == 5'd0 || rst)    rt_data = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (wr_ok) begin
         regs[wb_rd] <= wb_data;
      end
   end

   assign ex_rt = ID_EX[9:5];
   assign stall = !rst && ID_EX[148] && (ex_rt != 5'd0) && (ex_rt == rs || ex_rt == rt);

   // The bubble inserted on a stall clears MemRead, so each load stalls once
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ID_EX <= '0;
      else if (flush || stall)
         ID_EX <= '0;
      else
         ID_EX <= {ctrl, pc4, rs_data, rt_data, imm, rs, rt, rd};
   end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The module SHALL have no parameters; all widths are fixed at 32-bit data, 5-bit register index.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 IF_ID  input  64  fetch pipeline register: [63:32] PC+4, [31:0] instruction.
REQ-005 wb_we  input  1  writeback register-write enable.
REQ-006 wb_rd  input  5  writeback destination register index.
REQ-007 wb_data  input  32  writeback data.
REQ-008 flush  input  1  branch-taken squash from a later stage.
REQ-009 stall  output  1  load-use hazard; fetch SHALL hold PC and IF_ID while high.
REQ-010 ID_EX  output  152  registered bundle: [151:143] ctrl {RegWrite,MemtoReg,Branch,MemRead,MemWrite,RegDst,ALUSrc,ALUOp[1:0]}; [142:111] PC+4; [110:79] rs data; [78:47] rt data; [46:15] sign-extended imm; [14:10] rs; [9:5] rt; [4:0] rd.

Function
REQ-011 Field extraction: opcode = instr[31:26], rs = [25:21], rt = [20:16], rd = [15:11], imm = [15:0] sign-extended to 32 bits.
REQ-012 Control decode SHALL be combinational, ctrl bit order as REQ-010:
- opcode 0 (R-type): 1,0,0,0,0,1,0,10
- 35 (lw): 1,1,0,1,0,0,1,00
- 43 (sw): 0,0,0,0,1,0,1,00
- 4 (beq): 0,0,1,0,0,0,0,01
- 8 (addi): 1,0,0,0,0,0,1,00
- any other opcode: all zero (bubble).
REQ-013 Register file: 32 x 32 bits, two combinational read ports (rs, rt), one write port written on rising clk when wb_we=1.
REQ-014 Register 0 SHALL always read 0; writes to it are ignored.
REQ-015 Write-through bypass: if wb_we=1, wb_rd!=0 and wb_rd equals a read index, that port SHALL return wb_data in the same cycle.
REQ-016 stall SHALL be combinational: high iff ID_EX.MemRead=1, ID_EX.rt!=0, and ID_EX.rt equals current rs or current rt.
REQ-017 Each rising edge ID_EX SHALL load: all zeros if flush=1; else all zeros if stall=1; else the decoded bundle.
REQ-018 flush SHALL take priority over stall; the register-file write SHALL occur regardless of flush or stall.
REQ-019 Latency: instruction in IF_ID at edge N appears on ID_EX after edge N+1; a stalled instruction is re-decoded from the held IF_ID and issued one cycle later.
REQ-020 A stall SHALL last exactly one cycle per load (the inserted bubble clears ID_EX.MemRead).

Reset
REQ-021 While rst=1, ID_EX and all 32 registers SHALL be 0 immediately (asynchronously), stall SHALL be 0, and writes SHALL be blocked.
REQ-022 Reset asserted mid-stall SHALL drop stall in the same cycle; the first edge after release SHALL decode IF_ID normally.

Verification
REQ-023 Write r5=0x0000_00AA via wb, then IF_ID instr add r3,r5,r0 (0x00A01820) -> ID_EX rs data 0xAA, rd=3, ctrl 1_0000_1_0_10.
REQ-024 wb_we=1, wb_rd=7, wb_data=0x1234 in the same cycle as IF_ID sub r1,r7,r7 -> both read fields 0x1234 (bypass).
REQ-025 lw r2,0(r1) followed by add r4,r2,r3 -> stall=1 for exactly one cycle, ID_EX all zero that cycle, add issued next cycle.
REQ-026 flush=1 together with stall=1 -> ID_EX all zero; writes to r0 with wb_data=0xFFFF_FFFF -> r0 still reads 0.
REQ-027 addi r1,r0,-4 (0x2001FFFC) -> imm field 0xFFFF_FFFC; undefined opcode 0x3F -> ctrl 0.
REQ-028 Assert rst between clock edges with ID_EX nonzero -> ID_EX and stall 0 before the next edge; all registers read 0.
